nl_scheduler: RTL and testbench

Front-end controller for the NonLinear unit. It accepts predict, new-landmark and update requests from the RSA sequencer and queues them. It launches them one at a time with latched operands, matches each done against the request in flight, and returns registered results with a per-kind acknowledge. It sits between the RSA init/done interface and the NonLinear core, adds error reporting, and optionally adds a watchdog timeout.

---
 rtl/nl_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_nl_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nl_scheduler.sv
// nl_scheduler: front-end controller for the NonLinear unit.
// Queues predict / new-landmark / update requests, launches them one at a
// time with latched operands, matches the completion against the request in
// flight and returns registered results with a per-kind acknowledge.
// Optional feature macro: NL_SCHED_TIMEOUT_EN adds a WAIT-state watchdog.
// Kind encoding everywhere is one-hot {update, newlm, predict}.
module nl_scheduler #(
  parameter int DW      = 32,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 1000
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          req_predict,
  input  logic          req_newlm,
  input  logic          req_update,
  input  logic [DW-1:0] xk_i,
  input  logic [DW-1:0] yk_i,
  input  logic [DW-1:0] lkx_i,
  input  logic [DW-1:0] lky_i,
  input  logic [DW-1:0] xita_i,
  output logic          init_predict,
  output logic          init_newlm,
  output logic          init_update,
  output logic [DW-1:0] xk,
  output logic [DW-1:0] yk,
  output logic [DW-1:0] lkx,
  output logic [DW-1:0] lky,
  output logic [DW-1:0] xita,
  input  logic          done_predict,
  input  logic          done_newlm,
  input  logic          done_update,
  input  logic [DW-1:0] result_0,
  input  logic [DW-1:0] result_1,
  input  logic [DW-1:0] result_2,
  input  logic [DW-1:0] result_3,
  input  logic [DW-1:0] result_4,
  input  logic [DW-1:0] result_5,
  output logic          ack_predict,
  output logic          ack_newlm,
  output logic          ack_update,
  output logic [DW-1:0] res_0,
  output logic [DW-1:0] res_1,
  output logic [DW-1:0] res_2,
  output logic [DW-1:0] res_3,
  output logic [DW-1:0] res_4,
  output logic [DW-1:0] res_5,
  output logic          ack_err,
  output logic          busy,
  output logic [2:0]    pending,
  output logic [2:0]    err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_r;
  logic [2:0] sel_r;
  logic [2:0] req_s;
  logic [2:0] done_s;
  logic [2:0] clr_s;
  logic [2:0] pick_s;
  logic       done_sel_s;
  logic       spur_s;
  logic       ovf_s;
  logic       tmo_s;

`ifdef NL_SCHED_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  // Decode requests, completions, priority pick and error events.
  always_comb begin
    req_s      = {req_update, req_newlm, req_predict};
    done_s     = {done_update, done_newlm, done_predict};
    clr_s      = (state_r == RESP) ? sel_r : 3'b000;
    // A request coinciding with its own RESP clear is queued, not dropped.
    ovf_s      = |(req_s & pending & ~clr_s);
    done_sel_s = (state_r == WAIT) && (|(done_s & sel_r));
    if (pending[0]) begin
      pick_s = 3'b001;
    end else if (pending[2]) begin
      pick_s = 3'b100;
    end else if (pending[1]) begin
      pick_s = 3'b010;
    end else begin
      pick_s = 3'b000;
    end
    case (state_r)
      IDLE:    spur_s = |done_s;
      ISSUE:   spur_s = |done_s;
      WAIT:    spur_s = |(done_s & ~sel_r);
      RESP:    spur_s = 1'b0;
      default: spur_s = 1'b0;
    endcase
`ifdef NL_SCHED_TIMEOUT_EN
    // Timeout fires on the last WAIT cycle of the budget; a done there wins.
    tmo_s = (state_r == WAIT) && !done_sel_s && (tmo_cnt_r == TMO_LAST_C);
`else
    tmo_s = 1'b0;
`endif
  end

  // Request queue: one flag per kind, set on request, cleared on its RESP.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pending <= 3'b000;
    end else begin
      pending <= (pending & ~clr_s) | req_s;
    end
  end

  // Sticky error flags; a new event in the clear cycle survives the clear.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      err <= 3'b000;
    end else begin
      err <= (err_clr ? 3'b000 : err) | {ovf_s, spur_s, tmo_s};
    end
  end

  // Launch/wait/respond FSM with registered launch, ack and result outputs.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r <= IDLE;
      sel_r   <= 3'b000;
      {init_update, init_newlm, init_predict} <= 3'b000;
      {ack_update, ack_newlm, ack_predict}    <= 3'b000;
      ack_err <= 1'b0;
      busy    <= 1'b0;
      xk      <= {DW{1'b0}};
      yk      <= {DW{1'b0}};
      lkx     <= {DW{1'b0}};
      lky     <= {DW{1'b0}};
      xita    <= {DW{1'b0}};
      res_0   <= {DW{1'b0}};
      res_1   <= {DW{1'b0}};
      res_2   <= {DW{1'b0}};
      res_3   <= {DW{1'b0}};
      res_4   <= {DW{1'b0}};
      res_5   <= {DW{1'b0}};
`ifdef NL_SCHED_TIMEOUT_EN
      tmo_cnt_r <= {TMO_W{1'b0}};
`endif
    end else begin
      {init_update, init_newlm, init_predict} <= 3'b000;
      {ack_update, ack_newlm, ack_predict}    <= 3'b000;
      ack_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|pending) begin
            sel_r <= pick_s;
            xk    <= xk_i;
            yk    <= yk_i;
            lkx   <= lkx_i;
            lky   <= lky_i;
            xita  <= xita_i;
            {init_update, init_newlm, init_predict} <= pick_s;
            busy    <= 1'b1;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
`ifdef NL_SCHED_TIMEOUT_EN
          tmo_cnt_r <= {TMO_W{1'b0}};
`endif
          state_r <= WAIT;
        end
        WAIT: begin
          if (done_sel_s) begin
            res_0 <= result_0;
            res_1 <= result_1;
            res_2 <= result_2;
            res_3 <= result_3;
            res_4 <= result_4;
            res_5 <= result_5;
            {ack_update, ack_newlm, ack_predict} <= sel_r;
            state_r <= RESP;
          end else if (tmo_s) begin
            {ack_update, ack_newlm, ack_predict} <= sel_r;
            ack_err <= 1'b1;
            state_r <= RESP;
          end else begin
`ifdef NL_SCHED_TIMEOUT_EN
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
            state_r <= WAIT;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nl_scheduler.sv
// Self-checking bench for nl_scheduler: launch/ack scoreboard plus
// per-scenario timing and error-flag checks.
module tb_nl_scheduler;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst;
  logic          req_predict, req_newlm, req_update;
  logic [DW-1:0] xk_i, yk_i, lkx_i, lky_i, xita_i;
  logic          init_predict, init_newlm, init_update;
  logic [DW-1:0] xk, yk, lkx, lky, xita;
  logic          done_predict, done_newlm, done_update;
  logic [DW-1:0] result_0, result_1, result_2, result_3, result_4, result_5;
  logic          ack_predict, ack_newlm, ack_update;
  logic [DW-1:0] res_0, res_1, res_2, res_3, res_4, res_5;
  logic          ack_err, busy;
  logic [2:0]    pending, err;
  logic          err_clr;

  nl_scheduler #(.DW(DW), .TMO_W(16), .TMO_CYC(8)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .req_predict(req_predict), .req_newlm(req_newlm), .req_update(req_update),
    .xk_i(xk_i), .yk_i(yk_i), .lkx_i(lkx_i), .lky_i(lky_i), .xita_i(xita_i),
    .init_predict(init_predict), .init_newlm(init_newlm), .init_update(init_update),
    .xk(xk), .yk(yk), .lkx(lkx), .lky(lky), .xita(xita),
    .done_predict(done_predict), .done_newlm(done_newlm), .done_update(done_update),
    .result_0(result_0), .result_1(result_1), .result_2(result_2),
    .result_3(result_3), .result_4(result_4), .result_5(result_5),
    .ack_predict(ack_predict), .ack_newlm(ack_newlm), .ack_update(ack_update),
    .res_0(res_0), .res_1(res_1), .res_2(res_2),
    .res_3(res_3), .res_4(res_4), .res_5(res_5),
    .ack_err(ack_err), .busy(busy), .pending(pending), .err(err),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] xk;
    logic [DW-1:0] xita;
  } init_t;

  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] r0;
    logic [DW-1:0] r5;
    logic          aerr;
  } ack_t;

  init_t init_q[$];
  ack_t  ack_q[$];
  logic [DW-1:0] mdl_r0 = '0;
  logic [DW-1:0] mdl_r5 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack_p = 0, n_ack_n = 0, n_ack_u = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every launch and every ack must match the next entry.
  always @(negedge clk) begin
    init_t ei;
    ack_t  ea;
    if ({init_update, init_newlm, init_predict} != 3'b000) begin
      checks++;
      if (init_q.size() == 0) begin
        errors++;
        $display("FAIL init_unexpected: got kind %b, expected no launch", {init_update, init_newlm, init_predict});
      end else begin
        ei = init_q.pop_front();
        if ({init_update, init_newlm, init_predict} !== ei.kind || xk !== ei.xk || xita !== ei.xita) begin
          errors++;
          $display("FAIL init_match: got kind %b xk %h xita %h, expected kind %b xk %h xita %h",
                   {init_update, init_newlm, init_predict}, xk, xita, ei.kind, ei.xk, ei.xita);
        end
      end
    end
    if ({ack_update, ack_newlm, ack_predict} != 3'b000) begin
      n_ack_p += int'(ack_predict);
      n_ack_n += int'(ack_newlm);
      n_ack_u += int'(ack_update);
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got kind %b, expected no ack", {ack_update, ack_newlm, ack_predict});
      end else begin
        ea = ack_q.pop_front();
        if ({ack_update, ack_newlm, ack_predict} !== ea.kind || res_0 !== ea.r0 || res_5 !== ea.r5 || ack_err !== ea.aerr) begin
          errors++;
          $display("FAIL ack_match: got kind %b res_0 %h res_5 %h ack_err %b, expected kind %b res_0 %h res_5 %h ack_err %b",
                   {ack_update, ack_newlm, ack_predict}, res_0, res_5, ack_err, ea.kind, ea.r0, ea.r5, ea.aerr);
        end
      end
    end
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  // Queue the expected launch (current operands) and the expected ack.
  task push_req(input logic [2:0] kind, input logic [DW-1:0] r0, input logic aerr);
    init_q.push_back('{kind: kind, xk: xk_i, xita: xita_i});
    if (!aerr) begin
      mdl_r0 = r0;
      mdl_r5 = r0 + 32'd5;
    end
    ack_q.push_back('{kind: kind, r0: mdl_r0, r5: mdl_r5, aerr: aerr});
  endtask

  task pulse_req(input logic [2:0] kind);
    {req_update, req_newlm, req_predict} = kind;
    step();
    {req_update, req_newlm, req_predict} = 3'b000;
  endtask

  task drive_done(input logic [2:0] kind, input logic [DW-1:0] r0);
    result_0 = r0;          result_1 = r0 + 32'd1; result_2 = r0 + 32'd2;
    result_3 = r0 + 32'd3;  result_4 = r0 + 32'd4; result_5 = r0 + 32'd5;
    {done_update, done_newlm, done_predict} = kind;
    step();
    {done_update, done_newlm, done_predict} = 3'b000;
  endtask

  task pulse_err_clr;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task wait_init(input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if ({init_update, init_newlm, init_predict} != 3'b000) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL init_wait: got no launch within %0d cycles, expected a launch", max);
    end
  endtask

  task wait_ack(input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if ({ack_update, ack_newlm, ack_predict} != 3'b000) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL ack_wait: got no ack within %0d cycles, expected an ack", max);
    end
  endtask

  task test_reset;
    sys_rst = 1'b1;
    step(); step(); step();
    @(negedge clk);
    checks++;
    if ({init_update, init_newlm, init_predict, ack_update, ack_newlm, ack_predict, ack_err, busy} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 00000000", {init_update, init_newlm, init_predict, ack_update, ack_newlm, ack_predict, ack_err, busy});
    end
    checks++;
    if (pending !== 3'b000 || err !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got pending %b err %b, expected 000 000", pending, err);
    end
    checks++;
    if (xk !== 32'h0 || xita !== 32'h0 || res_0 !== 32'h0 || res_5 !== 32'h0) begin
      errors++; $display("FAIL reset_data: got xk %h xita %h res_0 %h res_5 %h, expected zeros", xk, xita, res_0, res_5);
    end
    sys_rst = 1'b0;
    step();
  endtask

  task test_single_predict;
    int c0, at;
    xk_i = 32'h0001_0000; yk_i = 32'h0002_0000; lkx_i = 32'h0000_0011;
    lky_i = 32'h0000_0022; xita_i = 32'h0000_00A5;
    c0 = cyc;
    push_req(3'b001, 32'h0000_1234, 1'b0);
    pulse_req(3'b001);
    @(negedge clk);
    checks++;
    if (pending !== 3'b001 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pending: got pending %b busy %b, expected 001 0", pending, busy);
    end
    wait_init(6, at);
    checks++;
    if (at != c0 + 2 || busy !== 1'b1) begin
      errors++; $display("FAIL single_init_cycle: got cycle %0d busy %b, expected %0d 1", at - c0, busy, 2);
    end
    while (cyc < c0 + 10) step();
    drive_done(3'b001, 32'h0000_1234);
    wait_ack(6, at);
    checks++;
    if (at != c0 + 11) begin
      errors++; $display("FAIL single_ack_cycle: got cycle %0d, expected %0d", at - c0, 11);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pending !== 3'b000) begin
      errors++; $display("FAIL single_idle: got busy %b pending %b, expected 0 000", busy, pending);
    end
  endtask

  task test_priority;
    logic [2:0]    ord [3];
    logic [DW-1:0] rv  [3];
    int at, at2, prev_ack;
    ord[0] = 3'b001; ord[1] = 3'b100; ord[2] = 3'b010;
    rv[0] = 32'h0000_00A0; rv[1] = 32'h0000_00B0; rv[2] = 32'h0000_00C0;
    step();
    xk_i = 32'h2222_0000; xita_i = 32'h0000_0033;
    for (int i = 0; i < 3; i++) push_req(ord[i], rv[i], 1'b0);
    pulse_req(3'b111);
    prev_ack = -1;
    for (int i = 0; i < 3; i++) begin
      wait_init(10, at);
      if (i > 0) begin
        checks++;
        if (at != prev_ack + 2) begin
          errors++; $display("FAIL prio_gap: got init %0d cycles after ack, expected 2", at - prev_ack);
        end
      end
      step();
      drive_done(ord[i], rv[i]);
      wait_ack(6, at2);
      prev_ack = at2;
    end
    step();
    @(negedge clk);
    checks++;
    if (err !== 3'b000 || pending !== 3'b000) begin
      errors++; $display("FAIL prio_flags: got err %b pending %b, expected 000 000", err, pending);
    end
  endtask

  task test_overflow;
    int at, base;
    base = n_ack_u;
    step();
    xk_i = 32'h3333_0000;
    push_req(3'b100, 32'h0000_0055, 1'b0);
    pulse_req(3'b100);
    wait_init(6, at);
    step();
    pulse_req(3'b100);
    @(negedge clk);
    checks++;
    if (err !== 3'b100 || pending !== 3'b100) begin
      errors++; $display("FAIL ovf_err: got err %b pending %b, expected 100 100", err, pending);
    end
    drive_done(3'b100, 32'h0000_0055);
    wait_ack(6, at);
    repeat (6) step();
    @(negedge clk);
    checks++;
    if (n_ack_u - base != 1 || pending !== 3'b000) begin
      errors++; $display("FAIL ovf_ack_count: got %0d acks pending %b, expected 1 000", n_ack_u - base, pending);
    end
    pulse_err_clr();
    @(negedge clk);
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL ovf_clear: got err %b, expected 000", err);
    end
  endtask

  task test_spurious;
    int at, base;
    base = n_ack_n;
    step();
    xk_i = 32'h4444_0000;
    push_req(3'b001, 32'h0000_0077, 1'b0);
    pulse_req(3'b001);
    wait_init(6, at);
    step();
    drive_done(3'b010, 32'h0000_DEAD);
    @(negedge clk);
    checks++;
    if (err !== 3'b010 || busy !== 1'b1 || pending !== 3'b001 || n_ack_n != base) begin
      errors++; $display("FAIL spur_state: got err %b busy %b pending %b newlm acks %0d, expected 010 1 001 0", err, busy, pending, n_ack_n - base);
    end
    drive_done(3'b001, 32'h0000_0077);
    wait_ack(6, at);
    pulse_err_clr();
    @(negedge clk);
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL spur_clear: got err %b, expected 000", err);
    end
  endtask

`ifdef NL_SCHED_TIMEOUT_EN
  task test_timeout;
    int c, at;
    step();
    xk_i = 32'h5555_0000;
    push_req(3'b100, 32'h0, 1'b1);
    pulse_req(3'b100);
    wait_init(6, c);
    wait_ack(20, at);
    checks++;
    if (at != c + 9) begin
      errors++; $display("FAIL tmo_cycle: got ack %0d cycles after WAIT entry, expected 8", at - c - 1);
    end
    checks++;
    if (err !== 3'b001) begin
      errors++; $display("FAIL tmo_err: got err %b, expected 001", err);
    end
    pulse_err_clr();
  endtask
`else
  task test_no_timeout;
    int c, at;
    step();
    xk_i = 32'h5555_0000;
    push_req(3'b100, 32'h0000_0099, 1'b0);
    pulse_req(3'b100);
    wait_init(6, c);
    repeat (20) step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 3'b000 || ack_err !== 1'b0) begin
      errors++; $display("FAIL notmo_wait: got busy %b err %b ack_err %b, expected 1 000 0", busy, err, ack_err);
    end
    drive_done(3'b100, 32'h0000_0099);
    wait_ack(6, at);
  endtask
`endif

  task test_reset_mid_wait;
    int at, c0, acks;
    step();
    xk_i = 32'h6666_0000;
    push_req(3'b001, 32'h0000_0011, 1'b0);
    pulse_req(3'b001);
    wait_init(6, at);
    step();
    pulse_req(3'b010);
    @(negedge clk);
    checks++;
    if (pending !== 3'b011 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got pending %b busy %b, expected 011 1", pending, busy);
    end
    init_q.delete();
    ack_q.delete();
    mdl_r0 = '0;
    mdl_r5 = '0;
    acks = n_ack_p + n_ack_n + n_ack_u;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== 3'b000 || busy !== 1'b0 || err !== 3'b000 || res_0 !== 32'h0) begin
      errors++; $display("FAIL rst_mid: got pending %b busy %b err %b res_0 %h, expected 000 0 000 0", pending, busy, err, res_0);
    end
    repeat (8) step();
    @(negedge clk);
    checks++;
    if (n_ack_p + n_ack_n + n_ack_u != acks) begin
      errors++; $display("FAIL rst_no_ack: got %0d acks after reset, expected 0", n_ack_p + n_ack_n + n_ack_u - acks);
    end
    step();
    xk_i = 32'h7777_0000;
    c0 = cyc;
    push_req(3'b001, 32'h0000_4321, 1'b0);
    pulse_req(3'b001);
    wait_init(6, at);
    checks++;
    if (at != c0 + 2) begin
      errors++; $display("FAIL rst_fresh_init: got cycle %0d, expected 2", at - c0);
    end
    step();
    drive_done(3'b001, 32'h0000_4321);
    wait_ack(6, at);
  endtask

  initial begin
    sys_rst = 1'b1; err_clr = 1'b0;
    {req_update, req_newlm, req_predict} = 3'b000;
    {done_update, done_newlm, done_predict} = 3'b000;
    xk_i = '0; yk_i = '0; lkx_i = '0; lky_i = '0; xita_i = '0;
    result_0 = '0; result_1 = '0; result_2 = '0;
    result_3 = '0; result_4 = '0; result_5 = '0;
    test_reset();
    test_single_predict();
    test_priority();
    test_overflow();
    test_spurious();
`ifdef NL_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    repeat (3) step();
    checks++;
    if (init_q.size() != 0 || ack_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d launches %0d acks outstanding, expected 0 0", init_q.size(), ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
